// File: rtl/pile_pkg.sv
// Shared constants and FSM encoding for the brick-stack keeper and its renderer.
package pile_pkg;

  localparam logic [2:0] HMAX = 3'd7;

  localparam logic [4:0] COUL_FOND   = 5'b00000;
  localparam logic [4:0] COUL_BRIQUE = 5'b10110;
  localparam logic [4:0] COUL_FLASH  = 5'b11111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLASH = 2'd1,
    SHIFT = 2'd2
  } etat_t;

endpackage

// File: rtl/rendu_pile.sv
// Pixel renderer for the three-column stack: maps hpos/vpos to a brick cell and
// registers the resulting colour (one clock of latency).
module rendu_pile
  import pile_pkg::*;
#(
  parameter int X0        = 256,
  parameter int COL_SHIFT = 6,
  parameter int Y_BASE    = 480,
  parameter int ROW_SHIFT = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  hauteur_gauche,
  input  logic [2:0]  hauteur_centre,
  input  logic [2:0]  hauteur_droite,
  input  logic [10:0] hpos,
  input  logic [10:0] vpos,
  input  logic        flash_row,
  output logic [4:0]  couleur
);

  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic [11:0]        col;
  logic [11:0]        row;
  logic               col_ok;
  logic               row_ok;
  logic [2:0]         hauteur_sel;
  logic               brique;
  logic [4:0]         couleur_next;

  // Negative offsets mark pixels left of the stack or below its floor.
  assign dx     = $signed({1'b0, hpos}) - $signed(12'(X0));
  assign dy     = $signed(12'(Y_BASE - 1)) - $signed({1'b0, vpos});
  assign col    = $unsigned(dx >>> COL_SHIFT);
  assign row    = $unsigned(dy >>> ROW_SHIFT);
  assign col_ok = !dx[11] && (col <= 12'd2);
  assign row_ok = !dy[11];

  always_comb begin
    hauteur_sel = 3'd0;
    case (col[1:0])
      2'd0:    hauteur_sel = hauteur_gauche;
      2'd1:    hauteur_sel = hauteur_centre;
      default: hauteur_sel = hauteur_droite;
    endcase
  end

  assign brique = col_ok && row_ok && (row < {9'd0, hauteur_sel});

  always_comb begin
    couleur_next = COUL_FOND;
    if (brique) begin
      if (flash_row && (row == 12'd0)) couleur_next = COUL_FLASH;
      else                             couleur_next = COUL_BRIQUE;
    end
  end

  // ---- stage p1: registered colour ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) couleur <= COUL_FOND;
    else       couleur <= couleur_next;
  end

endmodule

// File: rtl/pile_briques.sv
// Stack keeper: column heights, bottom-row clear FSM with flash timed on pulse
// edges, full-stack flag and score. Score register built only with PILE_SCORE_EN.
module pile_briques
  import pile_pkg::*;
#(
  parameter int X0           = 256,
  parameter int COL_SHIFT    = 6,
  parameter int Y_BASE       = 480,
  parameter int ROW_SHIFT    = 5,
  parameter int FLASH_PULSES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PlusGauche,
  input  logic        PlusCentre,
  input  logic        PlusDroite,
  input  logic        pulse,
  input  logic [10:0] hpos,
  input  logic [10:0] vpos,
  output logic [2:0]  hauteurGauche,
  output logic [2:0]  hauteurCentre,
  output logic [2:0]  hauteurDroite,
  output logic        Efface,
  output logic        Plein,
  output logic [7:0]  Score,
  output logic [4:0]  Couleur
);

  etat_t      etat;
  etat_t      etat_next;
  logic       pulse_q;
  logic       pulse_edge;
  logic [3:0] cnt;
  logic       phase;
  logic       all_up;
  logic       shift_now;
  logic       flash_row;
  logic [2:0] next_gauche;
  logic [2:0] next_centre;
  logic [2:0] next_droite;

  // In the shift cycle the height is at least 1, so a landing strobe cancels the decrement.
  function automatic logic [2:0] next_height(input logic [2:0] h, input logic plus,
                                             input logic shift);
    if (shift)                  return h - 3'd1 + {2'b00, plus};
    else if (plus && h != HMAX) return h + 3'd1;
    else                        return h;
  endfunction

  assign pulse_edge = pulse & ~pulse_q;
  assign all_up     = (hauteurGauche != 3'd0) && (hauteurCentre != 3'd0)
                   && (hauteurDroite != 3'd0);
  assign shift_now  = (etat == SHIFT) && !Plein;

  assign next_gauche = next_height(hauteurGauche, PlusGauche, shift_now);
  assign next_centre = next_height(hauteurCentre, PlusCentre, shift_now);
  assign next_droite = next_height(hauteurDroite, PlusDroite, shift_now);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pulse_q <= 1'b0;
    else       pulse_q <= pulse;
  end

  // ---- stage p1: heights and full flag, frozen once the stack is full ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hauteurGauche <= 3'd0;
      hauteurCentre <= 3'd0;
      hauteurDroite <= 3'd0;
      Plein         <= 1'b0;
    end else if (!Plein) begin
      hauteurGauche <= next_gauche;
      hauteurCentre <= next_centre;
      hauteurDroite <= next_droite;
      Plein         <= (next_gauche == HMAX) || (next_centre == HMAX)
                    || (next_droite == HMAX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) etat <= IDLE;
    else       etat <= etat_next;
  end

  always_comb begin
    etat_next = etat;
    case (etat)
      IDLE:    if (all_up) etat_next = FLASH;
      FLASH:   if (pulse_edge && (cnt == 4'(FLASH_PULSES - 1))) etat_next = SHIFT;
      SHIFT:   etat_next = IDLE;
      default: etat_next = IDLE;
    endcase
    if (Plein) etat_next = IDLE;
  end

  always_comb begin
    Efface    = (etat != IDLE) && !Plein;
    flash_row = (etat == FLASH) && phase && !Plein;
  end

  // Counter and phase idle at zero outside FLASH, so entry always starts fresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= 4'd0;
      phase <= 1'b0;
    end else if (etat != FLASH) begin
      cnt   <= 4'd0;
      phase <= 1'b0;
    end else if (pulse_edge) begin
      cnt   <= cnt + 4'd1;
      phase <= ~phase;
    end
  end

`ifdef PILE_SCORE_EN
  logic [7:0] score_r;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          score_r <= 8'd0;
    else if (shift_now) score_r <= sat_inc8(score_r);
  end

  assign Score = score_r;
`else
  assign Score = 8'd0;
`endif

  rendu_pile #(
    .X0       (X0),
    .COL_SHIFT(COL_SHIFT),
    .Y_BASE   (Y_BASE),
    .ROW_SHIFT(ROW_SHIFT)
  ) u_rendu (
    .clk           (clk),
    .reset         (reset),
    .hauteur_gauche(hauteurGauche),
    .hauteur_centre(hauteurCentre),
    .hauteur_droite(hauteurDroite),
    .hpos          (hpos),
    .vpos          (vpos),
    .flash_row     (flash_row),
    .couleur       (Couleur)
  );

endmodule

// File: tb/tb_pile_briques.sv
// Scoreboard bench for pile_briques: a game-level model predicts every output
// after each clock; a monitor compares the DUT against the queued predictions.
module tb_pile_briques;

  localparam int FP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PlusGauche = 1'b0, PlusCentre = 1'b0, PlusDroite = 1'b0;
  logic        pulse = 1'b0;
  logic [10:0] hpos = '0, vpos = '0;
  logic [2:0]  hauteurGauche, hauteurCentre, hauteurDroite;
  logic        Efface, Plein;
  logic [7:0]  Score;
  logic [4:0]  Couleur;

  pile_briques dut (
    .clk(clk), .reset(reset),
    .PlusGauche(PlusGauche), .PlusCentre(PlusCentre), .PlusDroite(PlusDroite),
    .pulse(pulse), .hpos(hpos), .vpos(vpos),
    .hauteurGauche(hauteurGauche), .hauteurCentre(hauteurCentre),
    .hauteurDroite(hauteurDroite), .Efface(Efface), .Plein(Plein),
    .Score(Score), .Couleur(Couleur)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int target;
    int hg, hc, hd;
    int ef, pl, sc, col;
  } exp_t;
  exp_t q[$];

  // Game-level model: column heights, clear progress, full flag, score.
  int mh[3];
  int mpl, msc, mcnt, mph, mpq;
  int clearing;   // 0 none, 1 flashing, 2 removing bottom row

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) mh[i] = 0;
    mpl = 0; msc = 0; mcnt = 0; mph = 0; mpq = 0; clearing = 0;
  endtask

  function automatic int model_colour(input int hp, input int vp);
    int c, r;
    if (hp < 256 || hp >= 256 + 3 * 64 || vp >= 480) return 0;
    c = (hp - 256) / 64;
    r = (479 - vp) / 32;
    if (r >= mh[c]) return 0;
    if (clearing == 1 && mph == 1 && mpl == 0 && r == 0) return 31;
    return 22;
  endfunction

  task automatic model_step(input int g, input int c, input int d, input int p,
                            input int hp, input int vp, output exp_t e);
    int plus[3];
    int nh[3];
    int edg, full;
    plus[0] = g; plus[1] = c; plus[2] = d;
    e.col = model_colour(hp, vp);
    edg = (p == 1 && mpq == 0) ? 1 : 0;
    mpq = p;
    if (mpl == 1) begin
      clearing = 0;
    end else begin
      full = (mh[0] >= 1 && mh[1] >= 1 && mh[2] >= 1) ? 1 : 0;
      for (int i = 0; i < 3; i++) begin
        if (clearing == 2) nh[i] = mh[i] - 1 + plus[i];
        else               nh[i] = (mh[i] + plus[i] > 7) ? 7 : mh[i] + plus[i];
      end
`ifdef PILE_SCORE_EN
      if (clearing == 2 && msc < 255) msc = msc + 1;
`endif
      if (clearing == 0) begin
        if (full == 1) begin clearing = 1; mcnt = 0; mph = 0; end
      end else if (clearing == 1) begin
        if (edg == 1) begin
          mcnt = mcnt + 1;
          mph = 1 - mph;
          if (mcnt == FP) clearing = 2;
        end
      end else begin
        clearing = 0;
      end
      for (int i = 0; i < 3; i++) begin
        mh[i] = nh[i];
        if (nh[i] == 7) mpl = 1;
      end
    end
    e.hg = mh[0]; e.hc = mh[1]; e.hd = mh[2];
    e.ef = (clearing != 0 && mpl == 0) ? 1 : 0;
    e.pl = mpl;
    e.sc = msc;
  endtask

  task automatic cycle(input int g, input int c, input int d, input int p,
                       input int hp = -1, input int vp = -1);
    exp_t e;
    int h, v;
    h = (hp < 0) ? int'($urandom_range(150, 520)) : hp;
    v = (vp < 0) ? int'($urandom_range(250, 520)) : vp;
    @(posedge clk); #1;
    PlusGauche = g[0]; PlusCentre = c[0]; PlusDroite = d[0];
    pulse = p[0]; hpos = 11'(h); vpos = 11'(v);
    model_step(g, c, d, p, h, v, e);
    e.target = edge_n + 1;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #5;
    reset = 1'b1;
    PlusGauche = 0; PlusCentre = 0; PlusDroite = 0; pulse = 0; hpos = '0; vpos = '0;
    #1;
    chk("rst_hauteurGauche", int'(hauteurGauche), 0);
    chk("rst_hauteurCentre", int'(hauteurCentre), 0);
    chk("rst_hauteurDroite", int'(hauteurDroite), 0);
    chk("rst_Efface", int'(Efface), 0);
    chk("rst_Plein", int'(Plein), 0);
    chk("rst_Score", int'(Score), 0);
    chk("rst_Couleur", int'(Couleur), 0);
    q.delete();
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Monitor: compare the DUT against the prediction made for this clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #4;
      while (q.size() > 0 && q[0].target <= edge_n) begin
        e = q.pop_front();
        if (e.target == edge_n && !reset) begin
          chk("hauteurGauche", int'(hauteurGauche), e.hg);
          chk("hauteurCentre", int'(hauteurCentre), e.hc);
          chk("hauteurDroite", int'(hauteurDroite), e.hd);
          chk("Efface", int'(Efface), e.ef);
          chk("Plein", int'(Plein), e.pl);
          chk("Score", int'(Score), e.sc);
          chk("Couleur", int'(Couleur), e.col);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d",
             checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int sc1, done, lvl;
    model_reset();
    do_reset();

    // Two left, one centre: no clear yet.
    cycle(1, 0, 0, 0); cycle(1, 0, 0, 0); cycle(0, 1, 0, 0); cycle(0, 0, 0, 0);
    chk("seq1_hg", int'(hauteurGauche), 2);
    chk("seq1_hc", int'(hauteurCentre), 1);
    chk("seq1_hd", int'(hauteurDroite), 0);
    chk("seq1_Efface", int'(Efface), 0);
    chk("seq1_Score", int'(Score), 0);

    // One right completes the row; four pulse edges clear it.
    cycle(0, 0, 1, 0); cycle(0, 0, 0, 0);
    chk("seq2_Efface_before", int'(Efface), 0);
    cycle(0, 0, 0, 0);
    chk("seq2_Efface_rise", int'(Efface), 1);
    for (int i = 0; i < FP; i++) begin cycle(0, 0, 0, 1); cycle(0, 0, 0, 0); end
    cycle(0, 0, 0, 0);
`ifdef PILE_SCORE_EN
    sc1 = 1;
`else
    sc1 = 0;
`endif
    chk("seq2_hg", int'(hauteurGauche), 1);
    chk("seq2_hc", int'(hauteurCentre), 0);
    chk("seq2_hd", int'(hauteurDroite), 0);
    chk("seq2_Efface_fall", int'(Efface), 0);
    chk("seq2_Score", int'(Score), sc1);

    // Simultaneous strobes, then a left strobe landing in the removal cycle.
    do_reset();
    cycle(1, 1, 1, 0);
    done = 0;
    for (int i = 0; i < 40 && done == 0; i++) begin
      if (clearing == 2) begin cycle(1, 0, 0, 0); done = 1; end
      else               cycle(0, 0, 0, i % 2);
    end
    cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
    chk("seq3_hg", int'(hauteurGauche), 1);
    chk("seq3_hc", int'(hauteurCentre), 0);
    chk("seq3_hd", int'(hauteurDroite), 0);

    // Fill the centre column to the top; further strobes are ignored.
    do_reset();
    for (int i = 0; i < 7; i++) cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0); cycle(1, 0, 0, 0); cycle(0, 0, 0, 0);
    chk("seq4_hc", int'(hauteurCentre), 7);
    chk("seq4_hg", int'(hauteurGauche), 0);
    chk("seq4_Plein", int'(Plein), 1);

    // Renderer with heights 2,0,0.
    do_reset();
    cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0, 300, 470);
    cycle(0, 0, 0, 0, 300, 400);
    chk("seq5_brique", int'(Couleur), 22);
    cycle(0, 0, 0, 0, 100, 470);
    chk("seq5_fond_row", int'(Couleur), 0);
    cycle(0, 0, 0, 0);
    chk("seq5_fond_col", int'(Couleur), 0);

    // Reset two pulse edges into a clear: abandoned, nothing removed.
    do_reset();
    cycle(1, 1, 1, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1); cycle(0, 0, 0, 0); cycle(0, 0, 0, 1); cycle(0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, i % 2);
    chk("seq6_hg", int'(hauteurGauche), 0);
    chk("seq6_Efface", int'(Efface), 0);

    // Random play episodes.
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      lvl = 0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 2) == 0) lvl = 1 - lvl;
        cycle(($urandom_range(0, 11) == 0) ? 1 : 0,
              ($urandom_range(0, 11) == 0) ? 1 : 0,
              ($urandom_range(0, 11) == 0) ? 1 : 0, lvl);
      end
    end

    cycle(0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #5;
    chk("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
